// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// Memory stage and MEM/WB pipeline register of the five-stage RISC-V core.
// Performs byte/half/word loads and stores against an internal word-organised
// data memory, then registers load data and pass-through fields into W.
//
// Ports:
//   Clk, Rst        rising-edge clock, asynchronous active-low reset
//   ALUResM         byte address for loads/stores, ALU result otherwise
//   WriteDataM      store data (rs2)
//   RdM, PC4M, ImmM destination register, PC+4, immediate (pass-through)
//   Funct3M         access size / signedness
//   MemWriteM       store request
//   RegWriteM       register write enable
//   ResultSrcM      00 ALU, 01 load, 10 PC4, 11 Imm
//   StallW, FlushW  hold / bubble the MEM/WB register (flush wins)
//   *W outputs      registered W-stage values
//   ResultW         write-back value selected from the W registers
module mem_wb_stage #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] ALUResM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PC4M,
  input  logic [31:0] ImmM,
  input  logic [2:0]  Funct3M,
  input  logic        MemWriteM,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        StallW,
  input  logic        FlushW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResW,
  output logic [31:0] PC4W,
  output logic [31:0] ImmW,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic        MisalignW,
  output logic [31:0] ResultW
);

  localparam int AW = $clog2(DEPTH_WORDS);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

  // Data memory: no reset, contents survive Rst.
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx_s;
  logic [1:0]    lane_s;
  logic [31:0]   word_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic          is_load_s;
  logic [31:0]   load_data_s;
  logic          load_mis_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic          store_mis_s;
  logic          misalign_s;
  logic          store_en_s;

  // Upper address bits are ignored, so addresses wrap modulo the memory size.
  assign idx_s  = ALUResM[AW+1:2];
  assign lane_s = ALUResM[1:0];
  assign word_s = mem_q[idx_s];

  // Lane extraction and load formatting (little-endian).
  always_comb begin
    is_load_s   = (ResultSrcM == 2'b01);
    load_data_s = 32'h0000_0000;
    load_mis_s  = 1'b0;
    case (lane_s)
      2'd0:    byte_s = word_s[7:0];
      2'd1:    byte_s = word_s[15:8];
      2'd2:    byte_s = word_s[23:16];
      default: byte_s = word_s[31:24];
    endcase
    if (lane_s[1]) begin
      half_s = word_s[31:16];
    end else begin
      half_s = word_s[15:0];
    end
    case (Funct3M)
      3'b000: load_data_s = ext8(byte_s, 1'b1);
      3'b100: load_data_s = ext8(byte_s, 1'b0);
      3'b001: begin
        load_mis_s  = lane_s[0];
        load_data_s = ext16(half_s, 1'b1);
      end
      3'b101: begin
        load_mis_s  = lane_s[0];
        load_data_s = ext16(half_s, 1'b0);
      end
      3'b010: begin
        load_mis_s  = (lane_s != 2'b00);
        load_data_s = word_s;
      end
      default: load_data_s = 32'h0000_0000;
    endcase
    if (load_mis_s) begin
      load_data_s = 32'h0000_0000;
    end else begin
      load_data_s = load_data_s;
    end
  end

  // Store byte enables; data is replicated so each enabled lane sees its bytes.
  always_comb begin
    be_s        = 4'b0000;
    wdata_s     = WriteDataM;
    store_mis_s = 1'b0;
    case (Funct3M)
      3'b000: begin
        be_s    = 4'b0001 << lane_s;
        wdata_s = {4{WriteDataM[7:0]}};
      end
      3'b001: begin
        store_mis_s = lane_s[0];
        be_s        = lane_s[1] ? 4'b1100 : 4'b0011;
        wdata_s     = {2{WriteDataM[15:0]}};
      end
      3'b010: begin
        store_mis_s = (lane_s != 2'b00);
        be_s        = 4'b1111;
      end
      default: be_s = 4'b0000;
    endcase
  end

  assign misalign_s = (is_load_s & load_mis_s) | (MemWriteM & store_mis_s);
  // A store is blocked while stalled so a re-presented store commits once.
  assign store_en_s = MemWriteM & (be_s != 4'b0000) & ~store_mis_s &
                      ~FlushW & ~StallW & Rst;

  // Byte-lane write into the data memory.
  always_ff @(posedge Clk) begin
    if (store_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_q[idx_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
        end
      end
    end
  end

  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic [1:0]  result_src_q, result_src_d;
  logic        misalign_q, misalign_d;

  // MEM/WB next state: flush beats stall beats normal load.
  always_comb begin
    read_data_d  = read_data_q;
    alu_res_d    = alu_res_q;
    pc4_d        = pc4_q;
    imm_d        = imm_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    result_src_d = result_src_q;
    misalign_d   = misalign_q;
    if (FlushW) begin
      read_data_d  = 32'h0000_0000;
      alu_res_d    = 32'h0000_0000;
      pc4_d        = 32'h0000_0000;
      imm_d        = 32'h0000_0000;
      rd_d         = 5'd0;
      reg_write_d  = 1'b0;
      result_src_d = 2'b00;
      misalign_d   = 1'b0;
    end else if (!StallW) begin
      read_data_d  = is_load_s ? load_data_s : 32'h0000_0000;
      alu_res_d    = ALUResM;
      pc4_d        = PC4M;
      imm_d        = ImmM;
      rd_d         = RdM;
      reg_write_d  = RegWriteM & ~misalign_s;
      result_src_d = ResultSrcM;
      misalign_d   = misalign_s;
    end else begin
      misalign_d   = misalign_q;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      read_data_q  <= 32'h0000_0000;
      alu_res_q    <= 32'h0000_0000;
      pc4_q        <= 32'h0000_0000;
      imm_q        <= 32'h0000_0000;
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      misalign_q   <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      alu_res_q    <= alu_res_d;
      pc4_q        <= pc4_d;
      imm_q        <= imm_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      misalign_q   <= misalign_d;
    end
  end

  assign ReadDataW  = read_data_q;
  assign ALUResW    = alu_res_q;
  assign PC4W       = pc4_q;
  assign ImmW       = imm_q;
  assign RdW        = rd_q;
  assign RegWriteW  = reg_write_q;
  assign ResultSrcW = result_src_q;
  assign MisalignW  = misalign_q;

  // Write-back select.
  always_comb begin
    case (result_src_q)
      2'b00:   ResultW = alu_res_q;
      2'b01:   ResultW = read_data_q;
      2'b10:   ResultW = pc4_q;
      default: ResultW = imm_q;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] ALUResM, WriteDataM, PC4M, ImmM;
  logic [4:0]  RdM;
  logic [2:0]  Funct3M;
  logic        MemWriteM, RegWriteM, StallW, FlushW;
  logic [1:0]  ResultSrcM;
  logic [31:0] ReadDataW, ALUResW, PC4W, ImmW, ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;

  int n_vec  = 0;
  int n_fail = 0;

  mem_wb_stage #(.DEPTH_WORDS(1024)) dut (
    .Clk(Clk), .Rst(Rst), .ALUResM(ALUResM), .WriteDataM(WriteDataM),
    .RdM(RdM), .PC4M(PC4M), .ImmM(ImmM), .Funct3M(Funct3M),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .StallW(StallW), .FlushW(FlushW), .ReadDataW(ReadDataW), .ALUResW(ALUResW),
    .PC4W(PC4W), .ImmW(ImmW), .RdW(RdW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .MisalignW(MisalignW), .ResultW(ResultW)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        mw;
    logic        rw;
    logic [1:0]  src;
    logic [31:0] e_read;
    logic [31:0] e_result;
    logic        e_mis;
    logic        e_rw;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic [31:0] imm, input logic [2:0] f3,
                       input logic mw, input logic rw, input logic [1:0] src);
    ALUResM = addr; WriteDataM = wd; RdM = rd; PC4M = pc4; ImmM = imm;
    Funct3M = f3; MemWriteM = mw; RegWriteM = rw; ResultSrcM = src;
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input string nm, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [4:0] rd, input logic [2:0] f3, input logic mw,
                     input logic rw, input logic [1:0] src, input logic [31:0] e_read,
                     input logic [31:0] e_result, input logic e_mis, input logic e_rw);
    vec_t v;
    v.name = nm; v.addr = addr; v.wdata = wd; v.rd = rd;
    v.pc4 = 32'h0000_0044; v.imm = 32'h1234_5000;
    v.f3 = f3; v.mw = mw; v.rw = rw; v.src = src;
    v.e_read = e_read; v.e_result = e_result; v.e_mis = e_mis; v.e_rw = e_rw;
    vt.push_back(v);
  endtask

  initial begin
    Rst = 1'b0; StallW = 1'b0; FlushW = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 2'b00);

    //   name          addr          wdata         rd  f3      mw  rw  src    e_read        e_result      mis rw
    add("sw_dead",    32'h100, 32'hDEADBEEF, 5'd0, 3'b010, 1'b1, 1'b0, 2'b00, 32'h0,        32'h100,      1'b0, 1'b0);
    add("lb_103",     32'h103, 32'h0,        5'd1, 3'b000, 1'b0, 1'b1, 2'b01, 32'hFFFFFFDE, 32'hFFFFFFDE, 1'b0, 1'b1);
    add("lbu_103",    32'h103, 32'h0,        5'd2, 3'b100, 1'b0, 1'b1, 2'b01, 32'h000000DE, 32'h000000DE, 1'b0, 1'b1);
    add("lh_102",     32'h102, 32'h0,        5'd3, 3'b001, 1'b0, 1'b1, 2'b01, 32'hFFFFDEAD, 32'hFFFFDEAD, 1'b0, 1'b1);
    add("lhu_100",    32'h100, 32'h0,        5'd4, 3'b101, 1'b0, 1'b1, 2'b01, 32'h0000BEEF, 32'h0000BEEF, 1'b0, 1'b1);
    add("lw_100",     32'h100, 32'h0,        5'd5, 3'b010, 1'b0, 1'b1, 2'b01, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
    add("lb_100",     32'h100, 32'h0,        5'd6, 3'b000, 1'b0, 1'b1, 2'b01, 32'hFFFFFFEF, 32'hFFFFFFEF, 1'b0, 1'b1);
    add("lbu_101",    32'h101, 32'h0,        5'd7, 3'b100, 1'b0, 1'b1, 2'b01, 32'h000000BE, 32'h000000BE, 1'b0, 1'b1);
    add("sb_101",     32'h101, 32'hAAAAAA12, 5'd0, 3'b000, 1'b1, 1'b0, 2'b00, 32'h0,        32'h101,      1'b0, 1'b0);
    add("lw_after_sb",32'h100, 32'h0,        5'd8, 3'b010, 1'b0, 1'b1, 2'b01, 32'hDEAD12EF, 32'hDEAD12EF, 1'b0, 1'b1);
    add("lw_mis_102", 32'h102, 32'h0,        5'd9, 3'b010, 1'b0, 1'b1, 2'b01, 32'h0,        32'h0,        1'b1, 1'b0);
    add("sh_mis_103", 32'h103, 32'h0000FFFF, 5'd0, 3'b001, 1'b1, 1'b1, 2'b00, 32'h0,        32'h103,      1'b1, 1'b0);
    add("lw_unchg",   32'h100, 32'h0,        5'd10,3'b010, 1'b0, 1'b1, 2'b01, 32'hDEAD12EF, 32'hDEAD12EF, 1'b0, 1'b1);
    add("alu_op",     32'h1234,32'h0,        5'd11,3'b000, 1'b0, 1'b1, 2'b00, 32'h0,        32'h1234,     1'b0, 1'b1);
    add("res_pc4",    32'h1234,32'h0,        5'd12,3'b000, 1'b0, 1'b1, 2'b10, 32'h0,        32'h44,       1'b0, 1'b1);
    add("res_imm",    32'h1234,32'h0,        5'd13,3'b000, 1'b0, 1'b1, 2'b11, 32'h0,        32'h12345000, 1'b0, 1'b1);
    add("sw_alias",   32'h1000,32'hCAFEF00D, 5'd0, 3'b010, 1'b1, 1'b0, 2'b00, 32'h0,        32'h1000,     1'b0, 1'b0);
    add("lw_0000",    32'h0,   32'h0,        5'd14,3'b010, 1'b0, 1'b1, 2'b01, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b1);
    add("lw_bad_f3",  32'h100, 32'h0,        5'd15,3'b011, 1'b0, 1'b1, 2'b01, 32'h0,        32'h0,        1'b0, 1'b1);
    add("sh_102",     32'h102, 32'h1111ABCD, 5'd0, 3'b001, 1'b1, 1'b0, 2'b00, 32'h0,        32'h102,      1'b0, 1'b0);
    add("lw_after_sh",32'h100, 32'h0,        5'd16,3'b010, 1'b0, 1'b1, 2'b01, 32'hABCD12EF, 32'hABCD12EF, 1'b0, 1'b1);
    add("lh_102b",    32'h102, 32'h0,        5'd17,3'b001, 1'b0, 1'b1, 2'b01, 32'hFFFFABCD, 32'hFFFFABCD, 1'b0, 1'b1);
    add("sw_200_zero",32'h200, 32'h0,        5'd0, 3'b010, 1'b1, 1'b0, 2'b00, 32'h0,        32'h200,      1'b0, 1'b0);

    // Reset state.
    #2;
    chk("rst_result", ResultW, 32'h0);
    chk("rst_regwrite", {31'd0, RegWriteW}, 32'h0);
    step();
    step();
    @(negedge Clk);
    Rst = 1'b1;
    #4;

    // Table vectors: apply, clock once, check W outputs.
    foreach (vt[i]) begin
      drive(vt[i].addr, vt[i].wdata, vt[i].rd, vt[i].pc4, vt[i].imm, vt[i].f3,
            vt[i].mw, vt[i].rw, vt[i].src);
      step();
      chk({vt[i].name, ".read"}, ReadDataW, vt[i].e_read);
      chk({vt[i].name, ".result"}, ResultW, vt[i].e_result);
      chk({vt[i].name, ".mis"}, {31'd0, MisalignW}, {31'd0, vt[i].e_mis});
      chk({vt[i].name, ".rw"}, {31'd0, RegWriteW}, {31'd0, vt[i].e_rw});
      chk({vt[i].name, ".rd"}, {27'd0, RdW}, {27'd0, vt[i].rd});
    end

    // Stall: W holds for 3 cycles, the stalled store commits on release.
    drive(32'h777, 32'h0, 5'd3, 32'h0, 32'h0, 3'b000, 1'b0, 1'b1, 2'b00);
    step();
    drive(32'h200, 32'h55, 5'd0, 32'h0, 32'h0, 3'b010, 1'b1, 1'b0, 2'b00);
    StallW = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall.alures", ALUResW, 32'h777);
      chk("stall.result", ResultW, 32'h777);
      chk("stall.rd", {27'd0, RdW}, 32'd3);
    end
    StallW = 1'b0;
    step();
    chk("unstall.alures", ALUResW, 32'h200);
    drive(32'h200, 32'h0, 5'd4, 32'h0, 32'h0, 3'b010, 1'b0, 1'b1, 2'b01);
    step();
    chk("lw_200", ResultW, 32'h55);

    // Flush squashes the store and bubbles W; flush wins over stall.
    drive(32'h200, 32'h99, 5'd6, 32'h8, 32'h9, 3'b010, 1'b1, 1'b1, 2'b11);
    FlushW = 1'b1;
    StallW = 1'b1;
    step();
    chk("flush_stall.imm", ImmW, 32'h0);
    chk("flush_stall.alures", ALUResW, 32'h0);
    StallW = 1'b0;
    step();
    chk("flush.pc4", PC4W, 32'h0);
    chk("flush.rd", {27'd0, RdW}, 32'h0);
    FlushW = 1'b0;
    drive(32'h200, 32'h0, 5'd4, 32'h0, 32'h0, 3'b010, 1'b0, 1'b1, 2'b01);
    step();
    chk("lw_200_after_flush", ResultW, 32'h55);

    // Async reset mid-run with a store pending: outputs clear immediately, no write.
    drive(32'h100, 32'h11111111, 5'd5, 32'h0, 32'h0, 3'b010, 1'b1, 1'b1, 2'b00);
    #2;
    Rst = 1'b0;
    #1;
    chk("rst_mid.result", ResultW, 32'h0);
    chk("rst_mid.read", ReadDataW, 32'h0);
    chk("rst_mid.rd", {27'd0, RdW}, 32'h0);
    chk("rst_mid.rw", {31'd0, RegWriteW}, 32'h0);
    step();
    step();
    chk("rst_hold.alures", ALUResW, 32'h0);
    drive(32'h100, 32'h0, 5'd7, 32'h0, 32'h0, 3'b010, 1'b0, 1'b1, 2'b01);
    @(negedge Clk);
    Rst = 1'b1;
    step();
    chk("lw_after_rst", ResultW, 32'hABCD12EF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
